// File: rtl/chocorol_pkg.sv
// Shared types and constants for the chocorol program sequencer: instruction
// field widths, ALU opcodes, sequencer state encoding and opcode helpers.
package chocorol_pkg;

  localparam int INSTR_W = 20;
  localparam int ADDR_W  = 6;
  localparam int OPC_W   = 8;
  localparam int DATA_W  = 32;

  localparam logic [OPC_W-1:0] OP_SUMA  = 8'h00;
  localparam logic [OPC_W-1:0] OP_RESTA = 8'h01;
  localparam logic [OPC_W-1:0] OP_AND   = 8'h02;
  localparam logic [OPC_W-1:0] OP_OR    = 8'h03;
  localparam logic [OPC_W-1:0] OP_MUL   = 8'h07;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    PUSH  = 3'd3,
    FIN   = 3'd4
  } seq_state_e;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] instr_dl1(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: ADDR_W];
  endfunction

  function automatic logic opcode_is_legal(input logic [OPC_W-1:0] opc);
    logic legal_s;
    case (opc)
      OP_SUMA, OP_RESTA, OP_AND, OP_OR, OP_MUL: legal_s = 1'b1;
      default:                                  legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/chocorol_secuenciador_if.sv
// Host/datapath/result bundle of the chocorol sequencer. The slave modport is
// the sequencer's view, the master modport is the host/datapath/consumer view.
interface chocorol_secuenciador_if #(
  parameter int AW = 4
);
  import chocorol_pkg::*;

  logic                prog_we;
  logic [AW-1:0]       prog_addr;
  logic [INSTR_W-1:0]  prog_data;
  logic                start;
  logic [AW:0]         count;
  logic                busy;
  logic                done;
  logic [INSTR_W-1:0]  instruccion;
  logic [DATA_W-1:0]   q_final;
  logic                res_valid;
  logic                res_ready;
  logic [DATA_W-1:0]   res_data;
  logic [AW-1:0]       res_idx;
  logic                err;

  modport slave (
    input  prog_we, prog_addr, prog_data, start, count, q_final, res_ready,
    output busy, done, instruccion, res_valid, res_data, res_idx, err
  );

  modport master (
    output prog_we, prog_addr, prog_data, start, count, q_final, res_ready,
    input  busy, done, instruccion, res_valid, res_data, res_idx, err
  );

endinterface

// File: rtl/chocorol_prog_buf.sv
// Program buffer: DEPTH x INSTR_W register array with synchronous write and
// combinational read. Contents are intentionally not reset.
module chocorol_prog_buf
  import chocorol_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/chocorol_secuenciador.sv
// Program sequencer for the chocorol datapath: issues buffered instructions,
// waits an opcode-dependent latency and streams q_final over valid/ready.
// Optional illegal-opcode screening: define CHOCOROL_OPCODE_CHECK_EN.
module chocorol_secuenciador
  import chocorol_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  chocorol_secuenciador_if.slave bus
);

  localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  seq_state_e          state_r, state_s;
  logic [AW-1:0]       pc_r, pc_s;
  logic [AW:0]         cnt_r, cnt_s;
  logic [LAT_W-1:0]    wait_r, wait_s;
  logic [INSTR_W-1:0]  instr_r, instr_s;
  logic                res_valid_r, res_valid_s;
  logic [DATA_W-1:0]   res_data_r, res_data_s;
  logic [AW-1:0]       res_idx_r, res_idx_s;
  logic                err_r, err_s;
  logic                busy_r, done_r;
  logic [INSTR_W-1:0]  rd_word_s;
  logic                last_s;
  logic                buf_we_s;

  // Writes are only honoured while no run is in flight.
  assign buf_we_s = bus.prog_we && ((state_r == IDLE) || (state_r == FIN));

  chocorol_prog_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_buf (
    .clk   (clk),
    .we    (buf_we_s),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (pc_r),
    .rdata (rd_word_s)
  );

  assign last_s = ({1'b0, pc_r} == (cnt_r - (AW+1)'(1)));

  // Next-state and datapath-register update logic.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    cnt_s       = cnt_r;
    wait_s      = wait_r;
    instr_s     = instr_r;
    res_valid_s = res_valid_r;
    res_data_s  = res_data_r;
    res_idx_s   = res_idx_r;
    err_s       = err_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          err_s = 1'b0;
          if (bus.count != (AW+1)'(0)) begin
            cnt_s   = (bus.count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.count;
            pc_s    = {AW{1'b0}};
            state_s = ISSUE;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
`ifdef CHOCOROL_OPCODE_CHECK_EN
        if (!opcode_is_legal(instr_opcode(rd_word_s))) begin
          // Illegal word is skipped: nothing driven, no result produced.
          err_s = 1'b1;
          if (last_s) begin
            state_s = FIN;
          end else begin
            pc_s    = pc_r + AW'(1);
            state_s = ISSUE;
          end
        end else begin
          instr_s = rd_word_s;
          wait_s  = (instr_opcode(rd_word_s) == OP_MUL) ? LAT_W'(MUL_LAT) : LAT_W'(ALU_LAT);
          state_s = WAIT;
        end
`else
        instr_s = rd_word_s;
        wait_s  = (instr_opcode(rd_word_s) == OP_MUL) ? LAT_W'(MUL_LAT) : LAT_W'(ALU_LAT);
        state_s = WAIT;
`endif
      end
      WAIT: begin
        if (wait_r == LAT_W'(1)) begin
          res_data_s  = bus.q_final;
          res_idx_s   = pc_r;
          res_valid_s = 1'b1;
          state_s     = PUSH;
        end else begin
          wait_s = wait_r - LAT_W'(1);
        end
      end
      PUSH: begin
        if (res_valid_r && bus.res_ready) begin
          res_valid_s = 1'b0;
          if (last_s) begin
            state_s = FIN;
          end else begin
            pc_s    = pc_r + AW'(1);
            state_s = ISSUE;
          end
        end else begin
          state_s = PUSH;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= {AW{1'b0}};
      cnt_r       <= {(AW+1){1'b0}};
      wait_r      <= {LAT_W{1'b0}};
      instr_r     <= {INSTR_W{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {DATA_W{1'b0}};
      res_idx_r   <= {AW{1'b0}};
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      cnt_r       <= cnt_s;
      wait_r      <= wait_s;
      instr_r     <= instr_s;
      res_valid_r <= res_valid_s;
      res_data_r  <= res_data_s;
      res_idx_r   <= res_idx_s;
      err_r       <= err_s;
      busy_r      <= (state_s == ISSUE) || (state_s == WAIT) || (state_s == PUSH);
      done_r      <= (state_s == FIN);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.instruccion = instr_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_idx     = res_idx_r;
  assign bus.err         = err_r;

endmodule
